shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_ctrl.sv | 103 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: parallel-in, serial-out shift register with a valid/ready
// word intake, per-word bit length and direction, and a consumer stall input.
// Flow: IDLE accepts a word, SHIFT emits one bit per unstalled clock, and DONE
// pulses for one cycle before the block returns to IDLE.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    input  logic             in_msb_first,
    input  logic             pause,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LW-1:0]    cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic [LW-1:0]    len_clamped;

    // Requested lengths beyond the register width emit the whole word.
    assign len_clamped = (in_len > WIDTH_L) ? WIDTH_L : in_len;

    // Next-state and datapath decode for the three-state controller.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    cnt_d   = len_clamped;
                    dir_d   = in_msb_first;
                    state_d = (len_clamped == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!pause) begin
                    // Move every bit one place toward the output end, filling with 0.
                    shreg_d = dir_q ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_q <= LW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; an asynchronous reset discards any word in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every shreg stage load its neighbour's pre-edge value.
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Handshake and status come from registered state only.
    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    // Serial output; valid and last follow pause combinationally.
    assign sout       = (state_q == ST_SHIFT) & (dir_q ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign sout_valid = (state_q == ST_SHIFT) & ~pause;
    assign sout_last  = sout_valid & (cnt_q == LW'(1));

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed bench for shift_seq_ctrl (WIDTH=8). Expected
// serial bits are queued when a word is driven and popped whenever the DUT
// shows a valid bit; handshake and done timing are checked cycle by cycle.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int LW    = $clog2(WIDTH) + 1;

    logic             CLK;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LW-1:0]    in_len;
    logic             in_msb_first;
    logic             pause;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .LW(LW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_len       (in_len),
        .in_msb_first (in_msb_first),
        .pause        (pause),
        .sout         (sout),
        .sout_valid   (sout_valid),
        .sout_last    (sout_last),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs against their reset/idle values.
    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_sout"},       32'(sout),       32'd0);
        chk({tag, "_sout_valid"}, 32'(sout_valid), 32'd0);
        chk({tag, "_sout_last"},  32'(sout_last),  32'd0);
    endtask

    // Mid-cycle sample; any valid bit is compared against the scoreboard.
    task automatic sample();
        exp_t e;
        @(negedge CLK);
        if (sout_valid === 1'b1) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sout_bit",  32'(sout),      32'(e.b));
                chk("sout_last", 32'(sout_last), 32'(e.last));
            end
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    // One complete word: accept cycle, then SHIFT/DONE cycles with timing checks.
    // Pauses occupy relative cycles p_after+1 .. p_after+p_n. With noise set,
    // in_valid stays high and the word inputs churn throughout the transfer.
    task automatic run_word(input logic [WIDTH-1:0] data, input logic [LW-1:0] len,
                            input logic msb, input int p_after, input int p_n,
                            input bit noise);
        int   nb;
        int   d;
        logic p;
        nb = (int'(len) > WIDTH) ? WIDTH : int'(len);
        d  = nb + p_n + 1;
        in_valid     = 1'b1;
        in_data      = data;
        in_len       = len;
        in_msb_first = msb;
        pause        = noise;
        for (int i = 0; i < nb; i++) begin
            sb_q.push_back('{b: (msb ? data[WIDTH-1-i] : data[i]), last: (i == nb - 1)});
        end
        sample();
        chk("accept_in_ready",   32'(in_ready),   32'd1);
        chk("accept_busy",       32'(busy),       32'd0);
        chk("accept_sout_valid", 32'(sout_valid), 32'd0);
        adv();
        in_valid = noise;
        for (int j = 1; j <= d; j++) begin
            p = (p_n > 0) && (j > p_after) && (j <= p_after + p_n);
            pause = p || (noise && (j == d));
            if (noise) begin
                in_data      = WIDTH'($urandom);
                in_len       = LW'($urandom);
                in_msb_first = 1'($urandom);
            end
            sample();
            chk("busy",       32'(busy),       32'd1);
            chk("in_ready",   32'(in_ready),   32'd0);
            chk("done",       32'(done),       32'(j == d));
            chk("sout_valid", 32'(sout_valid), 32'((j < d) && !p));
            if (j == d) begin
                chk("done_sout",      32'(sout),      32'd0);
                chk("done_sout_last", 32'(sout_last), 32'd0);
            end
            adv();
        end
        in_valid = 1'b0;
        pause    = 1'b0;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        RST          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_len       = '0;
        in_msb_first = 1'b0;
        pause        = 1'b0;

        // Reset values, before and after the first edges.
        #2;
        chk_idle_outputs("reset_async");
        adv();
        adv();
        chk_idle_outputs("reset_held");
        RST = 1'b0;
        adv();
        chk_idle_outputs("reset_released");

        // MSB-first full word: 1,0,1,0,0,1,0,1.
        run_word(8'hA5, 4'd8, 1'b1, 0, 0, 1'b0);
        // LSB-first, four bits: 1,0,1,0.
        run_word(8'hA5, 4'd4, 1'b0, 0, 0, 1'b0);
        // Three stall cycles after the second bit.
        run_word(8'hF0, 4'd8, 1'b1, 2, 3, 1'b0);
        // Stall on the final bit of a short word.
        run_word(8'hC3, 4'd3, 1'b1, 2, 2, 1'b0);
        // Zero length: DONE straight from IDLE, no valid bits.
        run_word(8'hFF, 4'd0, 1'b1, 0, 0, 1'b0);
        // Over-length request clamps to the register width.
        run_word(8'h5B, 4'd12, 1'b0, 0, 0, 1'b0);

        // Reset during the 5th bit of a word; only four bits plus the 5th are seen.
        in_valid     = 1'b1;
        in_data      = 8'hA5;
        in_len       = 4'd8;
        in_msb_first = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{b: in_data[WIDTH-1-i], last: 1'b0});
        end
        sample();
        chk("rst_accept_in_ready", 32'(in_ready), 32'd1);
        adv();
        in_valid = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            sample();
            chk("rst_pre_valid", 32'(sout_valid), 32'd1);
            if (j < 5) begin
                adv();
            end
        end
        #1;
        RST = 1'b1;
        #1;
        chk_idle_outputs("rst_mid_async");
        adv();
        chk_idle_outputs("rst_mid_next");
        RST = 1'b0;
        chk("rst_sb_empty", 32'(sb_q.size()), 32'd0);
        run_word(8'h3C, 4'd8, 1'b1, 0, 0, 1'b0);

        // Held in_valid with churning inputs, then an immediate follow-on word.
        run_word(8'h96, 4'd8, 1'b0, 0, 0, 1'b1);
        run_word(8'h0F, 4'd5, 1'b1, 1, 1, 1'b0);

        sample();
        chk_idle_outputs("final_idle");
        chk("sb_final", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
